// File: rtl/rv32_pc_sequencer.sv
// rv32_pc_sequencer: RV32 instruction-fetch PC sequencer.
// It issues fetch requests to instruction memory, tracks the architectural PC,
// and handles stalls and trap/jump/branch redirects.
// Optional feature: define RV32_PC_MISALIGN_TRAP_EN to send misaligned redirect
// targets to TRAP_VECTOR and report them on misalign_o. When it is not defined,
// the low two target bits are cleared and misalign_o stays 0.
module rv32_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_target_i,
    input  logic        trap_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    output logic [31:0] pc_o,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_pc_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, STALL, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        misalign_q, misalign_d;

    logic        redirect;
    logic [31:0] raw_target;
    logic [31:0] target;
    logic        misalign_hit;

    // Select the winning redirect target. Priority is trap, then jump, then branch.
    always_comb begin
        redirect   = trap_i | jmp_i | br_taken_i;
        raw_target = trap_i ? TRAP_VECTOR : (jmp_i ? jmp_target_i : br_target_i);
`ifdef RV32_PC_MISALIGN_TRAP_EN
        misalign_hit = redirect && (raw_target[1:0] != 2'b00);
        target       = misalign_hit ? TRAP_VECTOR : raw_target;
`else
        misalign_hit = 1'b0;
        target       = {raw_target[31:2], 2'b00};
`endif
    end

    // Compute the next state and the next values of all registered outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can infer a latch.
        state_d       = state_q;
        pc_d          = redirect ? target : pc_q;
        addr_d        = addr_q;
        fetch_valid_d = 1'b0;
        fetch_pc_d    = fetch_pc_q;
        misalign_d    = misalign_hit;
        unique case (state_q)
            IDLE: begin
                // Any ack seen here belongs to a fetch abandoned by reset, so it is ignored.
                state_d = REQ;
                addr_d  = pc_q;
            end
            REQ: begin
                if (imem_ack_i) begin
                    if (!redirect) begin
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = addr_q;
                        pc_d          = pc_q + 32'd4;
                    end
                    if (stall_i) begin
                        state_d = STALL;
                    end else begin
                        state_d = REQ;
                        addr_d  = pc_d;
                    end
                end else if (redirect) begin
                    // Keep the stale request on the bus until memory accepts it.
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A redirect here only moves pc. An ack retires the stale fetch,
                // so the next request can go to the current pc.
                if (imem_ack_i) begin
                    if (stall_i) begin
                        state_d = STALL;
                    end else begin
                        state_d = REQ;
                        addr_d  = pc_d;
                    end
                end
            end
            STALL: begin
                if (!stall_i) begin
                    state_d = REQ;
                    addr_d  = pc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. An asynchronous reset abandons any outstanding fetch.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments, so all registers update together.
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VECTOR;
            addr_q        <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= RESET_VECTOR;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req_o    = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr_o   = addr_q;
    assign pc_o          = pc_q;
    assign fetch_valid_o = fetch_valid_q;
    assign fetch_pc_o    = fetch_pc_q;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_rv32_pc_sequencer.sv
// tb_rv32_pc_sequencer: directed bench for rv32_pc_sequencer.
// The stimulus block pushes each expected fetch_pc_o into a queue.
// A monitor pops from that queue on every fetch_valid_o pulse.
// Other outputs are compared directly after each clock edge.
module tb_rv32_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = 32'h0;
    logic        jmp_i = 1'b0;
    logic [31:0] jmp_target_i = 32'h0;
    logic        trap_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] pc_o;
    logic        fetch_valid_o;
    logic [31:0] fetch_pc_o;
    logic        misalign_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_fetch_q[$];

    rv32_pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .br_taken_i   (br_taken_i),
        .br_target_i  (br_target_i),
        .jmp_i        (jmp_i),
        .jmp_target_i (jmp_target_i),
        .trap_i       (trap_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .pc_o         (pc_o),
        .fetch_valid_o(fetch_valid_o),
        .fetch_pc_o   (fetch_pc_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock edge, then wait until outputs are settled.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: each fetch_valid_o pulse must match the oldest expected fetch address.
    always @(negedge clk) begin
        if (fetch_valid_o) begin
            if (exp_fetch_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_fetch: got fetch_pc %h expected no fetch_valid", fetch_pc_o);
            end else begin
                check("fetch_pc", fetch_pc_o, exp_fetch_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state.
        tick();
        check("rst_pc", pc_o, 32'h0);
        check("rst_req", {31'b0, imem_req_o}, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_fpc", fetch_pc_o, 32'h0);
        check("rst_valid", {31'b0, fetch_valid_o}, 32'h0);
        check("rst_mis", {31'b0, misalign_o}, 32'h0);

        // Ack held high from reset release. The first ack arrives in IDLE and is ignored.
        reset = 1'b0;
        imem_ack_i = 1'b1;
        exp_fetch_q.push_back(32'h0);
        exp_fetch_q.push_back(32'h4);
        exp_fetch_q.push_back(32'h8);
        tick();
        check("seq_req", {31'b0, imem_req_o}, 32'h1);
        check("seq_addr0", imem_addr_o, 32'h0);
        tick();
        check("seq_addr4", imem_addr_o, 32'h4);
        tick();
        check("seq_addr8", imem_addr_o, 32'h8);
        tick();
        check("seq_pc12", pc_o, 32'hC);
        imem_ack_i = 1'b0;

        // Jump and branch together while REQ waits for ack. The jump wins and the FSM drains.
        jmp_i = 1'b1; jmp_target_i = 32'h200;
        br_taken_i = 1'b1; br_target_i = 32'h300;
        tick();
        jmp_i = 1'b0; br_taken_i = 1'b0;
        check("drain_pc", pc_o, 32'h200);
        check("drain_addr_held", imem_addr_o, 32'hC);
        check("drain_req", {31'b0, imem_req_o}, 32'h1);
        tick();
        check("drain_addr_wait", imem_addr_o, 32'hC);
        imem_ack_i = 1'b1;
        tick();
        check("post_drain_addr", imem_addr_o, 32'h200);
        exp_fetch_q.push_back(32'h200);
        tick();
        check("post_drain_pc", pc_o, 32'h204);

        // Stall across an ack. The request drops and pc advances by 4 but no further.
        stall_i = 1'b1;
        exp_fetch_q.push_back(32'h204);
        tick();
        imem_ack_i = 1'b0;
        check("stall_req", {31'b0, imem_req_o}, 32'h0);
        check("stall_pc", pc_o, 32'h208);
        tick();
        check("stall_pc_hold", pc_o, 32'h208);
        stall_i = 1'b0;
        tick();
        check("resume_req", {31'b0, imem_req_o}, 32'h1);
        check("resume_addr", imem_addr_o, 32'h208);

        // Jump to the top of the address space, then check that pc wraps to 0.
        jmp_i = 1'b1; jmp_target_i = 32'hFFFF_FFFC;
        tick();
        jmp_i = 1'b0;
        imem_ack_i = 1'b1;
        tick();
        check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        exp_fetch_q.push_back(32'hFFFF_FFFC);
        tick();
        imem_ack_i = 1'b0;
        check("wrap_pc", pc_o, 32'h0);

        // Misaligned jump target that arrives together with an ack. The fetch is discarded.
        jmp_i = 1'b1; jmp_target_i = 32'h202;
        imem_ack_i = 1'b1;
        tick();
        jmp_i = 1'b0;
        imem_ack_i = 1'b0;
`ifdef RV32_PC_MISALIGN_TRAP_EN
        check("mis_pc", pc_o, 32'h100);
        check("mis_pulse", {31'b0, misalign_o}, 32'h1);
`else
        check("mis_pc", pc_o, 32'h200);
        check("mis_pulse", {31'b0, misalign_o}, 32'h0);
`endif
        tick();
        check("mis_pulse_end", {31'b0, misalign_o}, 32'h0);

        // Trap has priority over jump. This also leaves the FSM in DRAIN.
        trap_i = 1'b1; jmp_i = 1'b1; jmp_target_i = 32'h400;
        tick();
        trap_i = 1'b0; jmp_i = 1'b0;
        check("trap_pc", pc_o, 32'h100);
        check("trap_req", {31'b0, imem_req_o}, 32'h1);

        // Asynchronous reset in DRAIN. A later ack seen in IDLE must be ignored.
        reset = 1'b1;
        #1;
        check("async_pc", pc_o, 32'h0);
        check("async_req", {31'b0, imem_req_o}, 32'h0);
        check("async_addr", imem_addr_o, 32'h0);
        tick();
        reset = 1'b0;
        imem_ack_i = 1'b1;
        tick();
        check("rr_addr", imem_addr_o, 32'h0);
        check("rr_req", {31'b0, imem_req_o}, 32'h1);
        check("rr_valid", {31'b0, fetch_valid_o}, 32'h0);
        exp_fetch_q.push_back(32'h0);
        tick();
        imem_ack_i = 1'b0;
        tick();
        tick();
        check("pending_fetches", exp_fetch_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32_pc_sequencer.md
RV32_PC_SEQUENCER -- requirements
Module: rv32_pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, SHALL be the target used for trap redirects.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 stall_i  in  1  pipeline stall; SHALL block issue of new fetches.
REQ-006 br_taken_i / br_target_i  in  1/32  taken-branch redirect and its target.
REQ-007 jmp_i / jmp_target_i  in  1/32  jump redirect and its target.
REQ-008 trap_i  in  1  trap redirect to TRAP_VECTOR.
REQ-009 imem_req_o / imem_addr_o  out  1/32  fetch request and its address.
REQ-010 imem_ack_i  in  1  fetch accept; the handshake completes on a cycle where req and ack are both high.
REQ-011 pc_o  out  32  architectural PC, i.e. the next address to fetch.
REQ-012 fetch_valid_o / fetch_pc_o  out  1/32  one-cycle pulse for a good fetch and the address it completed.
REQ-013 misalign_o  out  1  one-cycle pulse reporting a misaligned redirect target.

Function
REQ-014 FSM states SHALL be IDLE, REQ, STALL and DRAIN.
REQ-015 Redirect priority SHALL be trap > jmp > br_taken. The target is sampled in the cycle the redirect is high.
REQ-016 IDLE SHALL always go to REQ next cycle, latching imem_addr_o <= pc_o. imem_ack_i SHALL be ignored in IDLE.
REQ-017 REQ behaviour:
  - imem_req_o SHALL be 1.
  - imem_addr_o SHALL stay stable until ack.
REQ-018 In REQ, ack with no redirect SHALL:
  - pulse fetch_valid_o next cycle, with fetch_pc_o = imem_addr_o;
  - set pc_o <= pc_o+4;
  - go to REQ with the new address if stall_i=0, else go to STALL.
REQ-019 In REQ, a redirect without ack SHALL set pc_o <= target and go to DRAIN. imem_req_o and the old imem_addr_o SHALL be held.
REQ-020 In REQ, a redirect with ack SHALL discard the fetch (no fetch_valid_o), set pc_o <= target, and go to REQ (or STALL if stall_i=1).
REQ-021 DRAIN SHALL hold the request until ack, then discard that ack and go to REQ (STALL if stall_i=1). A redirect in DRAIN SHALL overwrite pc_o and keep the state in DRAIN.
REQ-022 STALL behaviour:
  - imem_req_o SHALL be 0.
  - The FSM SHALL return to REQ the cycle after stall_i falls, with imem_addr_o <= pc_o.
  - A redirect in STALL SHALL update pc_o only.
REQ-023 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-024 fetch_valid_o SHALL never assert for a discarded or post-redirect fetch, and never twice for one handshake.

Reset
REQ-025 When reset is asserted, outputs SHALL take these values immediately, independent of clk:
  - pc_o = RESET_VECTOR;
  - state = IDLE;
  - imem_req_o, fetch_valid_o and misalign_o = 0;
  - imem_addr_o and fetch_pc_o = RESET_VECTOR.
REQ-026 Reset mid-transaction SHALL abandon the outstanding fetch. An ack arriving after reset release, while in IDLE, SHALL be ignored.

Configuration
REQ-027 When macro RV32_PC_MISALIGN_TRAP_EN is defined, a winning redirect target with bits[1:0] != 0 SHALL:
  - pulse misalign_o next cycle;
  - load pc_o = TRAP_VECTOR instead of the target.
REQ-028 When RV32_PC_MISALIGN_TRAP_EN is undefined, redirect target bits[1:0] SHALL be forced to 0 and misalign_o SHALL be tied 0.

Verification
REQ-029 Reset then ack held high -> imem_addr_o sequence 0x0, 0x4, 0x8, with fetch_valid_o/fetch_pc_o following one cycle later.
REQ-030 jmp_i (target 0x200) with br_taken_i (target 0x300) while REQ waits for ack -> DRAIN. The old fetch is discarded and the next request goes to 0x200.
REQ-031 stall_i high across an ack -> req drops and pc_o holds +4. Drop stall_i -> req resumes at pc_o the next cycle.
REQ-032 Force pc_o to 0xFFFF_FFFC via jmp, then ack -> fetch_pc_o = 0xFFFF_FFFC and pc_o = 0x0.
REQ-033 jmp_target_i = 0x202:
  - with macro defined -> misalign_o pulses and pc_o = 0x100;
  - with macro undefined -> pc_o = 0x200.
REQ-034 Assert reset during DRAIN, then an ack arrives after release -> no fetch_valid_o, and the first request after release goes to RESET_VECTOR.
